bin2bcd_seq: RTL and testbench

//  Sequential (shift-add-3 / double-dabble) binary-to-BCD converter for the 4-digit
//  7-seg display path. Takes an unsigned binary count and produces four BCD digits.
//  The digits are ones, tens, hundred and thousand. They feed the digit-select mux

---
 rtl/bin2bcd_seq_if.sv | 25 ++
 rtl/bin2bcd_seq.sv | 131 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle between a bin2bcd_seq requester and the converter.
// The requester drives start/bin_in; the converter returns status and digits.
interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [3:0]       hundred;
  logic [3:0]       thousand;

  modport master (
    output start, bin_in,
    input  busy, done, ovf, ones, tens, hundred, thousand
  );

  modport slave (
    input  start, bin_in,
    output busy, done, ovf, ones, tens, hundred, thousand
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter for the 4-digit display.
// One adjust+shift step per clock; digits and ovf are registered and only
// change on the edge that enters DONE, so the display never sees partial data.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  bin2bcd_seq_if.slave     bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] shreg_q;
  logic [19:0]      bcd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic [15:0]      digits_q;
  logic             ovf_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [19:0]      bcd_adj;
  logic [19:0]      bcd_sh;
  logic [BIN_W-1:0] shreg_sh;
  logic             last_shift;
  logic             sat_d;

  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));
  assign sat_d      = (32'(bus.bin_in) > 32'd9999);

  // Datapath step: add 3 to every nibble >= 5, then shift {bcd, shreg} left by one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_sh   = {bcd_adj[18:0], shreg_q[BIN_W-1]};
    shreg_sh = {shreg_q[BIN_W-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is honoured only in IDLE; BIN_W shifts then one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so busy/done come straight out of flops.
  always_comb begin
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // Registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Conversion datapath and result registers; results publish only on the final shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shreg_q <= bus.bin_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= sat_d;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_sh;
          bcd_q   <= bcd_sh;
          cnt_q   <= cnt_q + 1'b1;
          if (last_shift) begin
            digits_q <= sat_q ? 16'h9999 : bcd_sh[15:0];
            ovf_q    <= sat_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;
  assign bus.ones     = digits_q[3:0];
  assign bus.tens     = digits_q[7:4];
  assign bus.hundred  = digits_q[11:8];
  assign bus.thousand = digits_q[15:12];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, a strided sweep of the
// decimal range, random in-range and overflow values, all against an
// arithmetic decimal-digit reference model.
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;
  localparam int LAT   = BIN_W;   // samples after the accepting edge until done is seen

  logic clk;
  logic rst_n;

  bin2bcd_seq_if #(.BIN_W(BIN_W)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int done_seen;
  int exp_done;

  // Count every done pulse the DUT produces, for the spurious-done check.
  always @(negedge clk) if (rst_n && bus.done) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by plain arithmetic, saturating above 9999.
  function automatic logic [16:0] ref_pack(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [16:0] dut_pack();
    return {bus.ovf, bus.thousand, bus.hundred, bus.tens, bus.ones};
  endfunction

  // One conversion starting from IDLE, with time at 1 unit after a rising edge.
  // Optionally injects a second start pulse (value 7777) at sample inj while busy.
  task automatic run_conv(input logic [BIN_W-1:0] v, input logic [BIN_W-1:0] v_late,
                          input int inj, output int lat, output int busy_cnt,
                          output bit held_ok, output logic [16:0] res,
                          output logic done_after);
    logic [16:0] prev;
    prev = dut_pack();
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bin_in = v_late;
    lat = -1; busy_cnt = 0; held_ok = 1'b1; res = '0;
    for (int k = 0; k < 40; k++) begin
      if (k == inj) begin
        bus.start  = 1'b1;
        bus.bin_in = 14'd7777;
      end else if (k == inj + 1) begin
        bus.start  = 1'b0;
      end
      if (bus.done) begin
        lat = k;
        res = dut_pack();
        break;
      end
      if (bus.busy) busy_cnt++;
      if (dut_pack() !== prev) held_ok = 1'b0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    done_after = bus.done;
    exp_done++;
  endtask

  task automatic conv_check(input string tag, input int v, input bit full);
    int lat, busy_cnt;
    bit held_ok;
    logic [16:0] res;
    logic done_after;
    run_conv(BIN_W'(v), BIN_W'($urandom), -1, lat, busy_cnt, held_ok, res, done_after);
    check({tag, "_digits"}, 32'(res), 32'(ref_pack(v)));
    check({tag, "_held"}, 32'(held_ok), 32'd1);
    if (full) begin
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_busy_cycles"}, busy_cnt, BIN_W);
      check({tag, "_done_width"}, 32'(done_after), 32'd0);
    end
  endtask

  initial begin
    int lat, busy_cnt, snap, t_first, t_second, v;
    bit held_ok;
    logic [16:0] res;
    logic done_after;

    n_tests = 0; n_fail = 0; done_seen = 0; exp_done = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_out", 32'(dut_pack()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero, then a typical value, then the saturation boundaries.
    conv_check("zero", 0, 1'b1);
    conv_check("v1234", 1234, 1'b1);
    conv_check("v9999", 9999, 1'b1);
    conv_check("v10000", 10000, 1'b1);
    conv_check("v16383", 16383, 1'b1);

    // Start ignored while busy; bin_in changes mid-run are ignored too.
    run_conv(14'd42, 14'd3333, 5, lat, busy_cnt, held_ok, res, done_after);
    check("busy_start_digits", 32'(res), 32'(ref_pack(42)));
    check("busy_start_latency", lat, LAT);
    check("busy_start_done_width", 32'(done_after), 32'd0);
    snap = done_seen;
    repeat (20) @(posedge clk);
    #1;
    check("busy_start_no_second_done", snap, done_seen);

    // Reset mid-conversion aborts with cleared outputs and no done.
    conv_check("v5678", 5678, 1'b1);
    snap = done_seen;
    bus.start  = 1'b1;
    bus.bin_in = 14'd321;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out", 32'(dut_pack()), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", snap, done_seen);
    conv_check("v0321", 321, 1'b1);

    // start held high: back-to-back conversions, one result per BIN_W+2 cycles.
    bus.start  = 1'b1;
    bus.bin_in = 14'd8642;
    t_first = -1; t_second = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin t_first = k; break; end
    end
    check("b2b_first_digits", 32'(dut_pack()), 32'(ref_pack(8642)));
    bus.bin_in = 14'd135;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      if (bus.done) begin t_second = k + 1; break; end
    end
    check("b2b_period", t_second, BIN_W + 2);
    check("b2b_second_digits", 32'(dut_pack()), 32'(ref_pack(135)));
    exp_done += 2;
    @(posedge clk); #1;

    // Strided sweep of the display range, then random in-range and overflow values.
    for (int i = 0; i <= 9999; i += 7) conv_check("sweep", i, 1'b0);
    for (int i = 0; i < 600; i++) begin
      v = int'($urandom_range(9999, 0));
      conv_check("rand", v, 1'b0);
    end
    for (int i = 0; i < 200; i++) begin
      v = int'($urandom_range(16383, 10000));
      conv_check("rand_ovf", v, 1'b0);
    end

    // Every done pulse must belong to an accepted start.
    repeat (4) @(posedge clk);
    #1;
    check("done_count", done_seen, exp_done);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
